// File: rtl/out_port_ctrl_if.sv
// Flit-buffer / crossbar handshake bundle for one router output port.
// The master drives requests and credit returns; the controller (slave) drives grant, select and forward.
interface out_port_ctrl_if #(
  parameter int CW = 3
);
  logic [3:0]    req;
  logic [3:0]    head;
  logic [3:0]    tail;
  logic          credit_in;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic          busy;
  logic          fwd;
  logic [CW-1:0] credits;

  modport master (
    output req, head, tail, credit_in,
    input  gnt, sel, busy, fwd, credits
  );

  modport slave (
    input  req, head, tail, credit_in,
    output gnt, sel, busy, fwd, credits
  );
endinterface

// File: rtl/out_port_ctrl.sv
// Wormhole output-port controller: round-robin head arbitration, per-packet lock, credit-gated forwarding.
// The downstream credit counter is built only when OUTCTRL_CREDIT_EN is defined.
module out_port_ctrl #(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic           clk,
  input  logic           reset,
  out_port_ctrl_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t     r_st;
  logic [1:0] r_ptr;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic       r_busy;
  logic [3:0] w_cand;
  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_credit_ok;
  logic       w_fwd;

  assign w_cand = bus.req & bus.head;

  // Round-robin pick: first head candidate at or after the priority pointer
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_fwd = !reset && (r_st == LOCKED) && bus.req[r_sel] && w_credit_ok;

`ifdef OUTCTRL_CREDIT_EN
  logic [CW-1:0] r_credits;

  assign w_credit_ok = (r_credits != {CW{1'b0}});

  // Downstream credit tracking; a credit returned while already full is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credits <= CW'(CREDITS);
    end else if (w_fwd && !bus.credit_in) begin
      r_credits <= r_credits - CW'(1);
    end else if (bus.credit_in && !w_fwd && (r_credits != CW'(CREDITS))) begin
      r_credits <= r_credits + CW'(1);
    end else begin
      r_credits <= r_credits;
    end
  end

  assign bus.credits = r_credits;
`else
  logic w_unused_credit_in;

  assign w_unused_credit_in = bus.credit_in;
  assign w_credit_ok        = 1'b1;
  assign bus.credits        = CW'(CREDITS);
`endif

  // Allocation / packet-lock FSM; sel deliberately keeps the last owner after the tail
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st   <= IDLE;
      r_ptr  <= 2'd0;
      r_gnt  <= 4'b0000;
      r_sel  <= 2'd0;
      r_busy <= 1'b0;
    end else begin
      case (r_st)
        IDLE: begin
          if (w_found) begin
            r_st   <= LOCKED;
            r_gnt  <= 4'b0001 << w_win;
            r_sel  <= w_win;
            r_busy <= 1'b1;
            r_ptr  <= w_win + 2'd1;
          end else begin
            r_st <= IDLE;
          end
        end
        LOCKED: begin
          if (w_fwd && bus.tail[r_sel]) begin
            r_st   <= IDLE;
            r_gnt  <= 4'b0000;
            r_busy <= 1'b0;
          end else begin
            r_st <= LOCKED;
          end
        end
        default: begin
          r_st   <= IDLE;
          r_gnt  <= 4'b0000;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.sel  = r_sel;
  assign bus.busy = r_busy;
  assign bus.fwd  = w_fwd;
endmodule

// File: tb/tb_out_port_ctrl.sv
// Self-checking bench for out_port_ctrl: vector table, directed corner sequences and random traffic
// compared against a packet-level reference model.
module tb_out_port_ctrl;
  localparam int CREDITS = 4;
  localparam int CW      = 3;
`ifdef OUTCTRL_CREDIT_EN
  localparam bit CRED_EN = 1'b1;
`else
  localparam bit CRED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  out_port_ctrl_if #(.CW(CW)) bus ();
  out_port_ctrl #(.CREDITS(CREDITS), .CW(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // reference model state: owner input (-1 = idle), pointer, last select, credits
  int m_own, m_ptr, m_sel, m_cr;

  // outputs captured mid-cycle
  logic [3:0]    a_gnt;
  logic [1:0]    a_sel;
  logic          a_busy, a_fwd;
  logic [CW-1:0] a_cr;

  typedef struct {
    logic [3:0] rq, hd, tl;
    logic       cin;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy, fwd;
    logic [2:0] cr;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_sel = 0; m_cr = CREDITS;
  endtask

  // one clock cycle: drive, sample at negedge, compare with model, advance model at posedge
  task automatic cycle(input logic [3:0] rq, input logic [3:0] hd, input logic [3:0] tl, input logic cin);
    logic [3:0] c;
    int w;
    bit f;
    bus.req = rq; bus.head = hd; bus.tail = tl; bus.credit_in = cin;
    @(negedge clk);
    a_gnt = bus.gnt; a_sel = bus.sel; a_busy = bus.busy; a_fwd = bus.fwd; a_cr = bus.credits;
    f = (m_own >= 0) && rq[m_own] && (!CRED_EN || m_cr != 0);
    chk("m_gnt", 32'(a_gnt), (m_own >= 0) ? 32'(4'b0001 << m_own) : 32'd0);
    chk("m_sel", 32'(a_sel), 32'(m_sel));
    chk("m_busy", 32'(a_busy), 32'(m_own >= 0));
    chk("m_fwd", 32'(a_fwd), 32'(f));
    chk("m_credits", 32'(a_cr), 32'(m_cr));
    @(posedge clk);
    if (m_own < 0) begin
      c = rq & hd;
      w = -1;
      for (int k = 0; k < 4; k++) if (w < 0 && c[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      if (w >= 0) begin m_own = w; m_sel = w; m_ptr = (w + 1) % 4; end
    end else if (f && tl[m_own]) begin
      m_own = -1;
    end
    if (CRED_EN) begin
      if (f && !cin) m_cr--;
      else if (cin && !f && m_cr < CREDITS) m_cr++;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = 4'b0; bus.head = 4'b0; bus.tail = 4'b0; bus.credit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_fwd", 32'(bus.fwd), 32'd0);
    chk("rst_credits", 32'(bus.credits), 32'(CREDITS));
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int n, sent;
    // alternating single-flit packets from inputs 0 and 2; credit returns on bubble cycles
    tv[0] = '{4'b0101, 4'b0101, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 3'd4};
    tv[1] = '{4'b0101, 4'b0101, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 3'd4};
    tv[2] = '{4'b0101, 4'b0101, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 3'd3};
    tv[3] = '{4'b0101, 4'b0101, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, 3'd4};
    tv[4] = '{4'b0101, 4'b0101, 4'b0101, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 3'd3};
    tv[5] = '{4'b0101, 4'b0101, 4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b1, 3'd4};
    tv[6] = '{4'b0101, 4'b0101, 4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 3'd3};
    tv[7] = '{4'b0101, 4'b0101, 4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1, 3'd4};

    model_reset();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(tv[i].rq, tv[i].hd, tv[i].tl, tv[i].cin);
      chk("tv_gnt", 32'(a_gnt), 32'(tv[i].gnt));
      chk("tv_sel", 32'(a_sel), 32'(tv[i].sel));
      chk("tv_busy", 32'(a_busy), 32'(tv[i].busy));
      chk("tv_fwd", 32'(a_fwd), 32'(tv[i].fwd));
      chk("tv_credits", 32'(a_cr), CRED_EN ? 32'(tv[i].cr) : 32'(CREDITS));
    end

    // 5-flit packet on input 1 while input 3 waits with a head
    do_reset();
    cycle(4'b1010, 4'b1010, 4'b1000, 1'b1);
    n = 0;
    for (int f = 1; f <= 5; f++) begin
      cycle(4'b1010, (f == 1) ? 4'b1010 : 4'b1000, (f == 5) ? 4'b1010 : 4'b1000, 1'b1);
      if (a_gnt == 4'b0010 && a_fwd) n++;
    end
    chk("pkt5_fwd_cycles", 32'(n), 32'd5);
    cycle(4'b1000, 4'b1000, 4'b1000, 1'b1);
    chk("pkt5_bubble_gnt", 32'(a_gnt), 32'd0);
    cycle(4'b1000, 4'b1000, 4'b1000, 1'b1);
    chk("pkt5_next_gnt", 32'(a_gnt), 32'(4'b1000));
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b0);

`ifdef OUTCTRL_CREDIT_EN
    // credit exhaustion on an 8-flit packet from input 0
    do_reset();
    cycle(4'b0001, 4'b0001, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0001, 4'b0000, 1'b0);
    chk("cr_first", 32'(a_cr), 32'd4);
    cycle(4'b0001, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 4'b0000, 1'b1);
    chk("cr_before_both", 32'(a_cr), 32'd2);
    cycle(4'b0001, 4'b0000, 4'b0000, 1'b0);
    chk("cr_fwd_and_cin_hold", 32'(a_cr), 32'd2);
    cycle(4'b0001, 4'b0000, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 4'b0000, 1'b1);
    chk("cr_stall_credits", 32'(a_cr), 32'd0);
    chk("cr_stall_fwd", 32'(a_fwd), 32'd0);
    cycle(4'b0001, 4'b0000, 4'b0000, 1'b0);
    chk("cr_return_credits", 32'(a_cr), 32'd1);
    chk("cr_return_fwd", 32'(a_fwd), 32'd1);
    cycle(4'b0001, 4'b0000, 4'b0000, 1'b0);
    chk("cr_empty_again_fwd", 32'(a_fwd), 32'd0);
    sent = 6;
    for (int k = 0; k < 20 && sent < 8; k++) begin
      cycle(4'b0001, 4'b0000, (sent == 7) ? 4'b0001 : 4'b0000, 1'b1);
      if (a_fwd) sent++;
    end
    chk("cr_pkt8_done", 32'(sent), 32'd8);
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b0);
    chk("cr_pkt8_idle", 32'(a_busy), 32'd0);
`endif

    // owner stalls 3 cycles mid-packet while input 2 waits with a head
    do_reset();
    cycle(4'b0101, 4'b0101, 4'b0000, 1'b0);
    cycle(4'b0101, 4'b0101, 4'b0000, 1'b0);
    chk("stall_first_fwd", 32'(a_fwd), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0100, 4'b0100, 4'b0000, 1'b0);
      chk("stall_fwd", 32'(a_fwd), 32'd0);
      chk("stall_gnt", 32'(a_gnt), 32'(4'b0001));
    end
    cycle(4'b0101, 4'b0100, 4'b0001, 1'b0);
    chk("stall_tail_fwd", 32'(a_fwd), 32'd1);
    chk("stall_tail_gnt", 32'(a_gnt), 32'(4'b0001));
    cycle(4'b0100, 4'b0100, 4'b0000, 1'b0);
    chk("stall_bubble", 32'(a_gnt), 32'd0);
    cycle(4'b0100, 4'b0100, 4'b0000, 1'b0);
    chk("stall_next_gnt", 32'(a_gnt), 32'(4'b0100));
    cycle(4'b0100, 4'b0000, 4'b0000, 1'b0);

    // asynchronous reset in the middle of input 2's packet (pointer at 3)
    #2;
    reset = 1'b1;
    #1;
    chk("arst_gnt", 32'(bus.gnt), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_fwd", 32'(bus.fwd), 32'd0);
    chk("arst_credits", 32'(bus.credits), 32'(CREDITS));
    do_reset();
    cycle(4'b1111, 4'b1111, 4'b1111, 1'b0);
    cycle(4'b1111, 4'b1111, 4'b1111, 1'b0);
    chk("arst_winner", 32'(a_gnt), 32'(4'b0001));

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cycle(4'($urandom), 4'($urandom), 4'($urandom_range(3, 0) == 0 ? 4'($urandom) : 4'($urandom) & 4'($urandom)),
            1'($urandom_range(1, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
